// File: rtl/serial_subtractor_if.sv
// Handshake and operand bundle for the bit-serial subtractor.
// master drives requests/operands, slave returns status and result.
interface serial_subtractor_if #(
    parameter int n = 8
);
    logic         start;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         bin;
    logic         ready;
    logic         done;
    logic [n-1:0] diff;
    logic         bout;

    modport master (
        output start, a, b, bin,
        input  ready, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output ready, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, one bit per clock LSB first, n-cycle latency.
// Define SERIAL_SUBTRACTOR_SATURATE_EN to floor underflowing results at 0.
module serial_subtractor #(
    parameter int n = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_subtractor_if.slave sub
);
    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic          accept;
    logic          last;
    logic [n-1:0]  a_sh;
    logic [n-1:0]  b_sh;
    logic [n-1:0]  res;
    logic [n-1:0]  res_nx;
    logic [n-1:0]  diff_nx;
    logic [n-1:0]  diff_q;
    logic [CW-1:0] cnt;
    logic          br;
    logic          br_nx;
    logic          d;
    logic          bout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (sub.start) begin
                    accept   = 1'b1;
                    state_nx = BUSY;
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (cnt == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result bits enter at the MSB so the LSB lands at bit 0 after n shifts.
    always_comb begin
        d      = a_sh[0] ^ b_sh[0] ^ br;
        br_nx  = (~a_sh[0] & b_sh[0])
               | (~(a_sh[0] ^ b_sh[0]) & br);
        res_nx = res >> 1;
        res_nx[n-1] = d;
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
        diff_nx = br_nx ? '0 : res_nx;
`else
        diff_nx = res_nx;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_sh <= sub.a;
            b_sh <= sub.b;
            br   <= sub.bin;
            res  <= '0;
            cnt  <= '0;
        end else if (state == BUSY) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            br   <= br_nx;
            res  <= res_nx;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff_q <= diff_nx;
                bout_q <= br_nx;
            end
        end
    end

    assign sub.ready = (state != BUSY);
    assign sub.done  = (state == DONE);
    assign sub.diff  = diff_q;
    assign sub.bout  = bout_q;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter n, default 8, setting the operand and result width in bits (legal range n >= 1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new subtraction; sampled only when ready=1.
REQ-005 The block SHALL have port a, input, n bits: minuend, sampled on the accepting edge.
REQ-006 The block SHALL have port b, input, n bits: subtrahend, sampled on the accepting edge.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, sampled on the accepting edge.
REQ-008 The block SHALL have port ready, output, 1 bit: high while the block can accept start.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port diff, output, n bits: result of the last completed operation.
REQ-011 The block SHALL have port bout, output, 1 bit: borrow-out of the last completed operation.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE; ready=1 in IDLE and DONE, ready=0 in BUSY.
REQ-013 Acceptance SHALL occur on a clk edge with start=1 and ready=1: a, b and bin are latched internally, the bit counter is cleared, and the state moves to BUSY.
REQ-014 In BUSY, each edge SHALL process one bit, LSB first, from a 1-bit borrow register: d = a_i ^ b_i ^ br; br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 Exactly n BUSY edges SHALL occur; on the n-th edge the state moves to DONE, diff and bout are loaded from the internal shift result, and done goes high.
REQ-016 done SHALL be high for exactly one cycle, in DONE, beginning n cycles after the accepting edge; DONE returns to IDLE on the next edge unless a new start is accepted.
REQ-017 start=1 in DONE SHALL be accepted (back-to-back) and go straight to BUSY with no IDLE cycle.
REQ-018 start during BUSY SHALL be ignored, and a, b and bin changes after acceptance SHALL have no effect on the in-flight result.
REQ-019 diff and bout SHALL change only on entry to DONE or on reset, and otherwise hold their value indefinitely.
REQ-020 The result SHALL satisfy {bout, diff} = a - b - bin over n+1 bits: bout=1 if and only if a < b + bin (unsigned).

Reset
REQ-021 While rst_n=0, the block SHALL immediately force: state=IDLE, ready=1, done=0, diff=0, bout=0, internal borrow, counter and shift registers=0.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first operation after release SHALL be correct.
REQ-023 start SHALL first be acceptable on the first rising clk edge with rst_n=1.

Configuration
REQ-024 The block SHALL support the macro SERIAL_SUBTRACTOR_SATURATE_EN.
- When defined: if the final borrow is 1, diff is loaded with 0 (unsigned floor), and bout still reports 1.
- When undefined: diff is the modular result (a - b - bin) mod 2^n.
- In both cases, latency and handshake SHALL be unchanged.

Verification (n=8 unless stated)
REQ-025 a=0x35, b=0x12, bin=0, start pulse -> done 8 cycles later; diff=0x23, bout=0; ready low for those 8 cycles.
REQ-026 a=0x00, b=0x01, bin=0 -> macro undefined: diff=0xFF, bout=1; macro defined: diff=0x00, bout=1.
REQ-027 a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0; then start held high in the DONE cycle with a=0x10, b=0x01 -> accepted with no IDLE gap, next done gives diff=0x0F.
REQ-028 start=1 with a=0xFF, b=0x00 applied in BUSY cycle 3 of an op with a=0x05, b=0x03 -> ignored; result diff=0x02, bout=0, one done pulse only.
REQ-029 rst_n low during BUSY cycle 4 -> immediate ready=1, done=0, diff=0x00, bout=0, no later done; a following op with a=0x09, b=0x04 -> diff=0x05.
REQ-030 n=1, a=0, b=0, bin=1 -> done 1 cycle after acceptance; diff=1, bout=1 (macro undefined) or diff=0, bout=1 (macro defined).
